// File: rtl/line_buffer_ring_pkg.sv
// line_buffer_ring_pkg: shared MGIA constants for the line buffer ring.
// Default word/address widths, ring size, ring index width, index wrap helper.
package line_buffer_ring_pkg;

    localparam int MGIA_DW   = 16;
    localparam int MGIA_AW   = 6;
    localparam int MGIA_NBUF = 2;
    // Ring index width; covers NBUF up to 4.
    localparam int MGIA_IW   = 2;

    // NBUF need not be a power of two, so wrap by explicit compare.
    function automatic logic [MGIA_IW-1:0] idx_inc(
        input logic [MGIA_IW-1:0] i,
        input int                 n
    );
        if (int'(i) == n - 1)
            return '0;
        return i + MGIA_IW'(1);
    endfunction

endpackage

// File: rtl/line_buffer_ring_line_ram.sv
// line_ram: simple dual-port sync RAM, NBUF*DEPTH x DW, registered read.
// Ports: CLK_I, RST_I (clears read reg), WE_I/W_ADR_I/W_DAT_I, R_ADR_I/R_DAT_O.
module line_ram
    import line_buffer_ring_pkg::*;
#(
    parameter int DW   = MGIA_DW,
    parameter int AW   = MGIA_AW,
    parameter int NBUF = MGIA_NBUF,
    parameter int MW   = $clog2(NBUF * (2**AW))
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic          WE_I,
    input  logic [MW-1:0] W_ADR_I,
    input  logic [DW-1:0] W_DAT_I,
    input  logic [MW-1:0] R_ADR_I,
    output logic [DW-1:0] R_DAT_O
);

    logic [DW-1:0] mem [NBUF * (2**AW)];

    always_ff @(posedge CLK_I) begin
        if (WE_I)
            mem[W_ADR_I] <= W_DAT_I;
    end

    // Output register with sync reset maps onto the block RAM output latch.
    always_ff @(posedge CLK_I) begin
        if (RST_I)
            R_DAT_O <= '0;
        else
            R_DAT_O <= mem[R_ADR_I];
    end

endmodule

// File: rtl/line_buffer_ring.sv
// line_buffer_ring: ring of NBUF line buffers between a fill stream and display.
// Ports: CLK_I, RST_I, LINE_I, F_ADR_I/F_DAT_O, S_STB_I/S_DAT_I/S_LAST_I/S_RDY_O, LEVEL_O, UNDERRUN_O.
module line_buffer_ring
    import line_buffer_ring_pkg::*;
#(
    parameter int DW   = MGIA_DW,
    parameter int AW   = MGIA_AW,
    parameter int NBUF = MGIA_NBUF
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic          LINE_I,
    input  logic [AW-1:0] F_ADR_I,
    output logic [DW-1:0] F_DAT_O,
    input  logic          S_STB_I,
    input  logic [DW-1:0] S_DAT_I,
    input  logic          S_LAST_I,
    output logic          S_RDY_O,
    output logic [1:0]    LEVEL_O,
    output logic          UNDERRUN_O
);

    localparam int IW = MGIA_IW;
    localparam int MW = $clog2(NBUF * (2**AW));

    logic [IW-1:0] disp_idx;
    logic [IW-1:0] fill_idx;
    logic [IW-1:0] full_cnt;
    logic [AW-1:0] wptr;

    logic          acc;
    logic          done;
    logic          adv;
    logic          und;
    logic [MW-1:0] w_adr;
    logic [MW-1:0] r_adr;

    // The fill buffer can never alias the display buffer while ready.
    assign S_RDY_O = int'(full_cnt) < NBUF - 1;

    assign acc  = S_STB_I & S_RDY_O & ~RST_I;
    assign done = acc & (S_LAST_I | (&wptr));
    assign adv  = LINE_I & ~RST_I & (full_cnt != '0);
    assign und  = LINE_I & ~RST_I & (full_cnt == '0);

    // {idx, addr} < NBUF*DEPTH, so dropping the spare top bit is lossless.
    assign w_adr = MW'({fill_idx, wptr});
    assign r_adr = MW'({disp_idx, F_ADR_I});

    assign LEVEL_O = 2'(full_cnt);

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            disp_idx   <= '0;
            fill_idx   <= IW'(1);
            full_cnt   <= '0;
            wptr       <= '0;
            UNDERRUN_O <= 1'b0;
        end else begin
            UNDERRUN_O <= und;
            if (acc)
                wptr <= done ? '0 : wptr + AW'(1);
            if (done)
                fill_idx <= idx_inc(fill_idx, NBUF);
            if (adv)
                disp_idx <= idx_inc(disp_idx, NBUF);
            unique case ({done, adv})
                2'b10:   full_cnt <= full_cnt + IW'(1);
                2'b01:   full_cnt <= full_cnt - IW'(1);
                default: full_cnt <= full_cnt;
            endcase
        end
    end

    line_ram #(
        .DW   (DW),
        .AW   (AW),
        .NBUF (NBUF),
        .MW   (MW)
    ) u_ram (
        .CLK_I   (CLK_I),
        .RST_I   (RST_I),
        .WE_I    (acc),
        .W_ADR_I (w_adr),
        .W_DAT_I (S_DAT_I),
        .R_ADR_I (r_adr),
        .R_DAT_O (F_DAT_O)
    );

endmodule
